// File: rtl/cpld_uart_responder.sv
// Device end of the CPLD UART bridge: bytes written on wrn go out on txd as 8N1, bytes framed on rxd are read back on rdn.
// Bus strobes take effect 3 clk after the pad edge; one-byte holding register, and writes while it is full are dropped.
module cpld_uart_responder #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdn,
  input  logic       wrn,
  input  logic [7:0] bus_data_i,
  output logic [7:0] bus_data_o,
  output logic       bus_data_oe,
  output logic       dataready,
  output logic       tbre,
  output logic       tsre,
  input  logic       rxd,
  output logic       txd,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0] rdn_sync, wrn_sync, rxd_sync;
  logic       rdn_q, wrn_q, rxd_q;
  logic       rdn_s, wrn_s, rxd_s;
  logic       rd_rise, wr_rise, rx_fall;

  // Strobes and rxd idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdn_sync <= 2'b11;
      wrn_sync <= 2'b11;
      rxd_sync <= 2'b11;
      rdn_q    <= 1'b1;
      wrn_q    <= 1'b1;
      rxd_q    <= 1'b1;
    end else begin
      rdn_sync <= {rdn_sync[0], rdn};
      wrn_sync <= {wrn_sync[0], wrn};
      rxd_sync <= {rxd_sync[0], rxd};
      rdn_q    <= rdn_sync[1];
      wrn_q    <= wrn_sync[1];
      rxd_q    <= rxd_sync[1];
    end
  end

  assign rdn_s   = rdn_sync[1];
  assign wrn_s   = wrn_sync[1];
  assign rxd_s   = rxd_sync[1];
  assign rd_rise = rdn_s & ~rdn_q;
  assign wr_rise = wrn_s & ~wrn_q;
  assign rx_fall = ~rxd_s & rxd_q;

  logic [7:0]    wr_data, hold, tx_shift;
  logic [1:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic          tx_bit_end, tx_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         wr_data <= 8'h00;
    else if (!wrn_s) wr_data <= bus_data_i;
  end

  assign tx_bit_end = (tx_cnt == BIT_LAST);
  assign tx_load    = !tbre && ((tx_state == ST_IDLE) || (tx_state == ST_STOP && tx_bit_end));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= 8'h00;
      tbre     <= 1'b1;
      tsre     <= 1'b1;
      txd      <= 1'b1;
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
    end else begin
      // A write only lands while the holding register is empty; tx_load only fires while it is full.
      if (wr_rise && tbre) begin
        hold <= wr_data;
        tbre <= 1'b0;
      end
      if (tx_load) begin
        tx_shift <= hold;
        tbre     <= 1'b1;
        tsre     <= 1'b0;
        txd      <= 1'b0;
        tx_state <= ST_START;
        tx_cnt   <= '0;
        tx_bit   <= 3'd0;
      end else if (tx_state != ST_IDLE) begin
        if (!tx_bit_end) begin
          tx_cnt <= tx_cnt + CW'(1);
        end else begin
          tx_cnt <= '0;
          case (tx_state)
            ST_START: begin
              tx_state <= ST_DATA;
              txd      <= tx_shift[0];
            end
            ST_DATA: begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              if (tx_bit == 3'd7) begin
                tx_state <= ST_STOP;
                txd      <= 1'b1;
              end else begin
                txd <= tx_shift[1];
              end
            end
            default: begin
              tx_state <= ST_IDLE;
              tsre     <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_buf;
  logic          rx_brk, rx_done;

  assign rx_done = (rx_state == ST_STOP) && !rx_brk && (rx_cnt == BIT_LAST) && rxd_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state  <= ST_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= 3'd0;
      rx_shift  <= 8'h00;
      rx_brk    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (rx_state)
        ST_IDLE: begin
          if (rx_fall) begin
            rx_state <= ST_START;
            rx_cnt   <= '0;
          end
        end
        ST_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_state <= rxd_s ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: begin
          // After a bad stop bit, hold off until the line returns high so a break is not seen as a new start.
          if (rx_brk) begin
            if (rxd_s) begin
              rx_brk   <= 1'b0;
              rx_state <= ST_IDLE;
            end
          end else if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rxd_s) begin
              rx_state <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              rx_brk    <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // A byte completing in the same cycle as a read clear wins and is not an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_buf    <= 8'h00;
      dataready <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (rx_done) begin
        rx_buf    <= rx_shift;
        dataready <= 1'b1;
        if (dataready && !rd_rise) overrun <= 1'b1;
      end else if (rd_rise) begin
        dataready <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus_data_oe <= 1'b0;
    else     bus_data_oe <= ~rdn_s;
  end

  assign bus_data_o = rx_buf;

endmodule

// File: tb/tb_cpld_uart_responder.sv
// Randomised bench for cpld_uart_responder with an independent serial-line model and queue-based scoreboards.
module tb_cpld_uart_responder;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int DIV      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst, rdn, wrn, rxd;
  logic [7:0] bus_data_i;
  logic [7:0] bus_data_o;
  logic       bus_data_oe, dataready, tbre, tsre, txd, frame_err, overrun;

  cpld_uart_responder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .rdn(rdn), .wrn(wrn),
    .bus_data_i(bus_data_i), .bus_data_o(bus_data_o), .bus_data_oe(bus_data_oe),
    .dataready(dataready), .tbre(tbre), .tsre(tsre),
    .rxd(rxd), .txd(txd), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_exp[$];
  logic [8:0] rx_exp[$];
  longint     tx_start_t[$];
  bit         tx_abort;
  int         fe_seen = 0;
  int         fe_expected = 0;
  bit         pending;
  logic [7:0] last_byte;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a good frame is always stored; it overruns if an unread byte is still held and no read clears it now.
  task automatic model_good_frame(input logic [7:0] b, input bit read_collides);
    logic ovr;
    ovr = pending && !read_collides;
    rx_exp.push_back({ovr, b});
    pending   = 1'b1;
    last_byte = b;
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus_data_i = b;
    wrn = 1'b0;
    repeat (4) @(negedge clk);
    wrn = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_glitch(input int len);
    rxd = 1'b0;
    repeat (len) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic do_read(input logic [7:0] exp_b);
    rdn = 1'b0;
    repeat (5) @(negedge clk);
    chk("read_oe", 32'(bus_data_oe), 1);
    chk("read_data", 32'(bus_data_o), 32'(exp_b));
    chk("read_dataready", 32'(dataready), 1);
    rdn = 1'b1;
    repeat (3) @(negedge clk);
    chk("read_dr_clear", 32'(dataready), 0);
    chk("read_oe_off", 32'(bus_data_oe), 0);
    pending = 1'b0;
  endtask

  // txd monitor: decode each frame mid-bit and compare with the queue of accepted writes.
  longint     mon_t0;
  logic [7:0] mon_b;
  logic       mon_start, mon_stop;
  initial begin
    forever begin
      @(negedge clk);
      if (txd === 1'b0 && rst === 1'b0) begin
        mon_t0 = $time;
        repeat (DIV / 2) @(negedge clk);
        mon_start = txd;
        for (int k = 0; k < 8; k++) begin
          repeat (DIV) @(negedge clk);
          mon_b[k] = txd;
        end
        repeat (DIV) @(negedge clk);
        mon_stop = txd;
        repeat (DIV / 2 - 1) @(negedge clk);
        if (tx_abort) begin
          tx_abort = 1'b0;
        end else begin
          tx_start_t.push_back(mon_t0);
          chk("tx_start_bit", 32'(mon_start), 0);
          chk("tx_stop_bit", 32'(mon_stop), 1);
          if (tx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got frame %0h, none expected", mon_b);
          end else begin
            chk("tx_byte", 32'(mon_b), 32'(tx_exp.pop_front()));
          end
        end
      end
    end
  end

  // Receive monitor: a byte is presented when dataready rises, or the held byte is replaced.
  logic       prev_dr = 1'b0;
  logic [7:0] prev_d  = 8'h00;
  logic [8:0] rx_e;
  initial begin
    forever begin
      @(negedge clk);
      if (dataready === 1'b1 && (!prev_dr || overrun === 1'b1 || bus_data_o !== prev_d)) begin
        if (rx_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got byte %0h, none expected", bus_data_o);
        end else begin
          rx_e = rx_exp.pop_front();
          chk("rx_byte", 32'(bus_data_o), 32'(rx_e[7:0]));
          chk("rx_overrun", 32'(overrun), 32'(rx_e[8]));
        end
      end
      prev_dr = dataready;
      prev_d  = bus_data_o;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (frame_err === 1'b1) fe_seen++;
    end
  end

  int         fe0;
  int         op;
  logic [7:0] rb;
  initial begin
    rst = 1'b1; rdn = 1'b1; wrn = 1'b1; rxd = 1'b1; bus_data_i = 8'h00;
    tx_abort = 1'b0; pending = 1'b0; last_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 1);
    chk("rst_tbre", 32'(tbre), 1);
    chk("rst_tsre", 32'(tsre), 1);
    chk("rst_dataready", 32'(dataready), 0);
    chk("rst_oe", 32'(bus_data_oe), 0);
    chk("rst_data", 32'(bus_data_o), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte: exact timing of tbre, start bit and tsre.
    tx_exp.push_back(8'hA5);
    write_byte(8'hA5);
    repeat (2) @(negedge clk);
    chk("tbre_2clk", 32'(tbre), 1);
    @(negedge clk);
    chk("tbre_3clk", 32'(tbre), 0);
    chk("txd_idle_3clk", 32'(txd), 1);
    @(negedge clk);
    chk("txd_start_4clk", 32'(txd), 0);
    chk("tsre_start_4clk", 32'(tsre), 0);
    chk("tbre_loaded", 32'(tbre), 1);
    repeat (159) @(negedge clk);
    chk("tsre_busy_159", 32'(tsre), 0);
    @(negedge clk);
    chk("tsre_done_160", 32'(tsre), 1);
    repeat (10) @(negedge clk);

    // Back-to-back frames, plus a write dropped while the holding register is full.
    tx_start_t.delete();
    tx_exp.push_back(8'h55);
    write_byte(8'h55);
    repeat (4) @(negedge clk);
    tx_exp.push_back(8'h0F);
    write_byte(8'h0F);
    repeat (4) @(negedge clk);
    write_byte(8'hFF);
    repeat (4) @(negedge clk);
    chk("tbre_full_after_drop", 32'(tbre), 0);
    repeat (340) @(negedge clk);
    chk("tx_b2b_frames", tx_start_t.size(), 2);
    if (tx_start_t.size() == 2)
      chk("tx_b2b_no_gap", 32'((tx_start_t[1] - tx_start_t[0]) / 10), 32'(10 * DIV));
    chk("tsre_after_b2b", 32'(tsre), 1);

    // Receive then read.
    model_good_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b1);
    repeat (8) @(negedge clk);
    do_read(8'h3C);

    // Stop bit low, then a short start glitch.
    fe0 = fe_seen;
    fe_expected++;
    send_frame(8'h81, 1'b0);
    repeat (8) @(negedge clk);
    chk("ferr_once", fe_seen - fe0, 1);
    chk("ferr_no_data", 32'(dataready), 0);
    fe0 = fe_seen;
    send_glitch(4);
    chk("glitch_no_ferr", fe_seen - fe0, 0);
    chk("glitch_no_byte", 32'(dataready), 0);

    // Overrun, then a read clear colliding with completion.
    model_good_frame(8'h11, 1'b0);
    send_frame(8'h11, 1'b1);
    repeat (8) @(negedge clk);
    model_good_frame(8'h22, 1'b0);
    send_frame(8'h22, 1'b1);
    repeat (8) @(negedge clk);
    chk("overrun_buf", 32'(bus_data_o), 'h22);
    chk("overrun_dr", 32'(dataready), 1);
    rdn = 1'b0;
    repeat (5) @(negedge clk);
    model_good_frame(8'h33, 1'b1);
    fork
      send_frame(8'h33, 1'b1);
      begin
        repeat (10 * DIV - 8) @(negedge clk);
        rdn = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    chk("collide_dr", 32'(dataready), 1);
    chk("collide_data", 32'(bus_data_o), 'h33);
    do_read(8'h33);

    // Randomised receive traffic.
    for (int i = 0; i < 12; i++) begin
      op = $urandom_range(0, 9);
      rb = 8'($urandom);
      if (op == 0) begin
        send_glitch($urandom_range(1, 5));
      end else if (op == 1) begin
        fe_expected++;
        send_frame(rb, 1'b0);
        repeat (8) @(negedge clk);
      end else begin
        model_good_frame(rb, 1'b0);
        send_frame(rb, 1'b1);
        repeat (8) @(negedge clk);
        if ($urandom_range(0, 1) == 1) do_read(last_byte);
      end
      chk("rand_rx_dr", 32'(dataready), 32'(pending));
    end

    // Randomised transmit traffic.
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      tx_exp.push_back(rb);
      write_byte(rb);
      repeat (200) @(negedge clk);
    end

    // Reset in the middle of a transmit frame with a byte pending and the bus driven.
    model_good_frame(8'h5A, 1'b0);
    send_frame(8'h5A, 1'b1);
    repeat (8) @(negedge clk);
    rdn = 1'b0;
    write_byte(8'hC3);
    repeat (10) @(negedge clk);
    tx_abort = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk("midrst_txd", 32'(txd), 1);
    chk("midrst_tbre", 32'(tbre), 1);
    chk("midrst_tsre", 32'(tsre), 1);
    chk("midrst_dataready", 32'(dataready), 0);
    chk("midrst_oe", 32'(bus_data_oe), 0);
    @(negedge clk);
    rdn = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pending = 1'b0;
    repeat (200) @(negedge clk);
    chk("midrst_rxbuf", 32'(bus_data_o), 0);

    chk("tx_queue_drained", tx_exp.size(), 0);
    chk("rx_queue_drained", rx_exp.size(), 0);
    chk("frame_err_total", fe_seen, fe_expected);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
